// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, LSU and byte-wide RAM port bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  clear;
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [31:0]           if_data;
  logic                  ls_valid;
  logic                  ls_wr;
  logic [1:0]            ls_size;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [31:0]           ls_wdata;
  logic                  ls_done;
  logic [31:0]           ls_rdata;
  logic                  io_buffer_full;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  modport master (
    output clear, if_valid, if_addr, ls_valid, ls_wr, ls_size, ls_addr, ls_wdata,
           io_buffer_full, mem_din,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  clear, if_valid, if_addr, ls_valid, ls_wr, ls_size, ls_addr, ls_wdata,
           io_buffer_full, mem_din,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/LSU arbiter serialising accesses onto a byte-wide RAM port
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_MASK_HI = 17
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_e                state_q, state_d;
  logic [2:0]            k_q, k_d, n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, byte_addr, mem_a_c;
  logic [31:0]           wdata_q, wdata_d, buf_q, buf_d;
  logic [31:0]           if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;
  logic                  owner_q, owner_d, last_q, last_d;
  logic                  if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic                  mem_wr_c, if_ok, ls_ok, pick_ls, io_stall;
  logic [7:0]            mem_dout_c;
  logic [1:0]            rd_idx, wr_idx;

  assign byte_addr = addr_q + ADDR_WIDTH'(k_q) - ADDR_WIDTH'(1);
  assign rd_idx    = 2'(k_q - 3'd2);
  assign wr_idx    = 2'(k_q - 3'd1);
  assign io_stall  = (addr_q[IO_MASK_HI -: 2] == 2'b11) && bus.io_buffer_full;

  // A requester whose done is visible this cycle is still busy and cannot be re-granted.
  assign if_ok   = bus.if_valid && !if_done_q;
  assign ls_ok   = bus.ls_valid && !ls_done_q;
  assign pick_ls = ls_ok && (!if_ok || (last_q == OWN_IF));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    owner_d    = owner_q;
    last_d     = last_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    mem_a_c    = '0;
    mem_wr_c   = 1'b0;
    mem_dout_c = 8'h00;
    case (state_q)
      IDLE: begin
        if (!bus.clear && (if_ok || ls_ok)) begin
          owner_d = pick_ls;
          last_d  = pick_ls;
          k_d     = 3'd1;
          buf_d   = '0;
          if (pick_ls) begin
            addr_d  = bus.ls_addr;
            wdata_d = bus.ls_wdata;
            case (bus.ls_size)
              2'b00:   n_d = 3'd1;
              2'b01:   n_d = 3'd2;
              default: n_d = 3'd4;
            endcase
            state_d = bus.ls_wr ? WRITE : READ;
          end else begin
            addr_d  = bus.if_addr;
            n_d     = 3'd4;
            state_d = READ;
          end
        end
      end
      READ: begin
        mem_a_c = byte_addr;
        if (bus.clear) begin
          state_d = IDLE;
        end else begin
          // RAM returns the byte one cycle after its address, so capture lags k by two.
          if (k_q >= 3'd2) buf_d[{rd_idx, 3'b000} +: 8] = bus.mem_din;
          if (k_q == n_q + 3'd1) begin
            state_d = IDLE;
            if (owner_q == OWN_LS) begin
              ls_done_d  = 1'b1;
              ls_rdata_d = buf_d;
            end else begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      WRITE: begin
        mem_a_c = byte_addr;
        if (!io_stall) begin
          mem_wr_c   = 1'b1;
          mem_dout_c = wdata_q[{wr_idx, 3'b000} +: 8];
          if (k_q == n_q) begin
            state_d   = IDLE;
            ls_done_d = 1'b1;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      owner_q    <= OWN_IF;
      last_q     <= OWN_LS;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign bus.if_done  = if_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.mem_a    = mem_a_c;
  assign bus.mem_wr   = mem_wr_c;
  assign bus.mem_dout = mem_dout_c;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [7:0] ram [0:4095];

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .IO_MASK_HI(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a[11:0]];
    if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] wexp [4];
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
    ram[12'h020] = 8'hEF; ram[12'h021] = 8'hBE;
    bus.clear = 0; bus.if_valid = 0; bus.if_addr = 0;
    bus.ls_valid = 0; bus.ls_wr = 0; bus.ls_size = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
    bus.io_buffer_full = 0; bus.mem_din = 0;
    step(); step();
    chk("rst_if_done", bus.if_done, 0);
    chk("rst_ls_done", bus.ls_done, 0);
    chk("rst_if_data", bus.if_data, 0);
    chk("rst_ls_rdata", bus.ls_rdata, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_dout", bus.mem_dout, 0);
    rst = 1;

    // tie after reset: fetch first, LSU half load granted on fetch done cycle
    step();
    bus.if_valid = 1; bus.if_addr = 32'h100;
    bus.ls_valid = 1; bus.ls_wr = 0; bus.ls_size = 2'b01; bus.ls_addr = 32'h20;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("fetch_mem_a", bus.mem_a, 32'h100 + i - 1);
      chk("fetch_mem_wr", bus.mem_wr, 0);
    end
    step(); chk("fetch_c5_done", bus.if_done, 0);
    step(); chk("fetch_c6_done", bus.if_done, 1);
    chk("fetch_data", bus.if_data, 32'h0000_0513);
    chk("fetch_c6_ls_done", bus.ls_done, 0);
    bus.if_valid = 0;
    step(); chk("half_mem_a0", bus.mem_a, 32'h20); chk("fetch_pulse_end", bus.if_done, 0);
    step(); chk("half_mem_a1", bus.mem_a, 32'h21);
    step(); chk("half_c9_done", bus.ls_done, 0);
    step(); chk("half_done", bus.ls_done, 1); chk("half_rdata", bus.ls_rdata, 32'h0000_BEEF);
    bus.ls_valid = 0;
    step(); chk("half_pulse_end", bus.ls_done, 0);

    // word store
    bus.ls_valid = 1; bus.ls_wr = 1; bus.ls_size = 2'b10; bus.ls_addr = 32'h40; bus.ls_wdata = 32'hDEAD_BEEF;
    wexp[0] = 8'hEF; wexp[1] = 8'hBE; wexp[2] = 8'hAD; wexp[3] = 8'hDE;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("st_mem_wr", bus.mem_wr, 1);
      chk("st_mem_a", bus.mem_a, 32'h40 + i - 1);
      chk("st_mem_dout", bus.mem_dout, wexp[i-1]);
      chk("st_early_done", bus.ls_done, 0);
    end
    step(); chk("st_done", bus.ls_done, 1); chk("st_wr_off", bus.mem_wr, 0);
    chk("st_ram", {ram[12'h43], ram[12'h42], ram[12'h41], ram[12'h40]}, 32'hDEAD_BEEF);
    bus.ls_valid = 0;

    // IO byte store with back-pressure
    step();
    bus.ls_valid = 1; bus.ls_wr = 1; bus.ls_size = 2'b00; bus.ls_addr = 32'h3_0000; bus.ls_wdata = 32'h41;
    bus.io_buffer_full = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("io_stall_wr", bus.mem_wr, 0);
      chk("io_stall_a", bus.mem_a, 32'h3_0000);
    end
    step(); bus.io_buffer_full = 0; #1;
    chk("io_wr", bus.mem_wr, 1); chk("io_dout", bus.mem_dout, 8'h41); chk("io_early_done", bus.ls_done, 0);
    step(); chk("io_done", bus.ls_done, 1); chk("io_wr_off", bus.mem_wr, 0);
    bus.ls_valid = 0;

    // clear aborts a fetch in cycle 3
    step();
    bus.if_valid = 1; bus.if_addr = 32'h100;
    step(); step(); step();
    bus.clear = 1; bus.if_valid = 0; #1;
    chk("clr_wr_c3", bus.mem_wr, 0);
    step(); bus.clear = 0; #1;
    chk("clr_idle_a", bus.mem_a, 0); chk("clr_idle_wr", bus.mem_wr, 0);
    for (int i = 0; i < 4; i++) begin
      step(); chk("clr_no_done", bus.if_done, 0);
    end

    // tie after a fetch grant: LSU wins; clear mid-store does not abort it
    bus.if_valid = 1; bus.if_addr = 32'h100;
    bus.ls_valid = 1; bus.ls_wr = 1; bus.ls_size = 2'b11; bus.ls_addr = 32'h44; bus.ls_wdata = 32'h1122_3344;
    step(); chk("rr_ls_wins", bus.mem_a, 32'h44); chk("rr_wr", bus.mem_wr, 1);
    step(); bus.clear = 1; #1; chk("cst_wr_c2", bus.mem_wr, 1); chk("cst_a_c2", bus.mem_a, 32'h45);
    step(); bus.clear = 0; #1; chk("cst_dout_c3", bus.mem_dout, 8'h22);
    step(); chk("cst_a_c4", bus.mem_a, 32'h47); chk("cst_dout_c4", bus.mem_dout, 8'h11);
    step(); chk("cst_done", bus.ls_done, 1);
    bus.ls_valid = 0;
    step(); chk("rr_fetch_a", bus.mem_a, 32'h100);
    step(); step(); step(); step();
    step(); chk("rr_fetch_done", bus.if_done, 1); chk("rr_fetch_data", bus.if_data, 32'h0000_0513);
    bus.if_valid = 0;

    // reset in the middle of a word store
    step();
    bus.ls_valid = 1; bus.ls_wr = 1; bus.ls_size = 2'b10; bus.ls_addr = 32'h80; bus.ls_wdata = 32'hCAFE_F00D;
    step(); step(); chk("rw_wr_before", bus.mem_wr, 1);
    rst = 0; #1;
    chk("rw_wr", bus.mem_wr, 0); chk("rw_a", bus.mem_a, 0); chk("rw_dout", bus.mem_dout, 0);
    chk("rw_ls_done", bus.ls_done, 0);
    bus.ls_valid = 0;
    step(); step();
    chk("rw_partial0", ram[12'h80], 8'h0D); chk("rw_partial1", ram[12'h81], 8'h00);
    rst = 1;
    bus.if_valid = 1; bus.if_addr = 32'h100;
    bus.ls_valid = 1; bus.ls_wr = 0; bus.ls_size = 2'b00; bus.ls_addr = 32'h20;
    step(); chk("rw_tie_fetch", bus.mem_a, 32'h100);
    step(); step(); step(); step();
    step(); chk("rw_fetch_done", bus.if_done, 1);
    bus.if_valid = 0;
    step(); step();
    step(); chk("byte_done", bus.ls_done, 1); chk("byte_rdata", bus.ls_rdata, 32'h0000_00EF);
    bus.ls_valid = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM/IO port of the CPU core between two requesters: instruction fetch (4-byte reads) and the load/store unit (1/2/4-byte reads or writes).
- Sits between the fetch unit, the LSU and the top-level RAM/HCI port inside riscv_top.
- Serialises multi-byte accesses, assembles little-endian words and honours the IO-buffer-full back-pressure.
- Round-robin arbitration between the two requesters; flush support.

Parameters:
- ADDR_WIDTH, 32, width of requester and memory address ports
- IO_MASK_HI, 17, top bit of the IO-region detect field; an access is IO when addr[IO_MASK_HI:IO_MASK_HI-1]==2'b11

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- clear  in  1  pipeline flush (mispredict), sampled synchronously
- if_valid  in  1  fetch request; held until if_done or clear
- if_addr  in  ADDR_WIDTH  fetch address
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched instruction, little-endian
- ls_valid  in  1  LSU request; held until ls_done
- ls_wr  in  1  1=store, 0=load
- ls_size  in  2  00 byte, 01 half, 10/11 word
- ls_addr  in  ADDR_WIDTH  LSU address
- ls_wdata  in  32  store data, low bytes first
- ls_done  out  1  one-cycle pulse: load data valid / store complete
- ls_rdata  out  32  load data, zero-extended
- io_buffer_full  in  1  IO output FIFO full
- mem_din  in  8  RAM read byte; valid one cycle after its address is driven
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_WIDTH  RAM address
- mem_wr  out  1  1=write this cycle

Behaviour:
- Reset (rst low, async): state IDLE; mem_wr, mem_a, mem_dout, if_done, ls_done, if_data, ls_rdata all 0; last_grant=LSU, so fetch wins the first tie.
- States: IDLE, READ, WRITE. N = bytes (1/2/4); byte index k counts 0..N.
- IDLE, cycle 0:
  - Request(s) seen.
  - Only one valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - Grant latches addr/size/wdata/owner and updates last_grant; state changes at end of cycle 0.
- READ, cycles 1..N:
  - mem_a = addr+k-1, mem_wr=0.
  - mem_din captured into byte k-2 at end of cycles 2..N+1.
  - done for the owner registered at end of cycle N+1, visible as a 1-cycle pulse in cycle N+2.
  - Data stable during the pulse.
  - Return to IDLE in cycle N+2; a new grant may be decided in that same cycle.
  - Fetch: 4-byte read, if_done in cycle 6.
- WRITE, cycles 1..N:
  - mem_wr=1, mem_a = addr+k-1, mem_dout = wdata byte k-1.
  - ls_done visible in cycle N+1; mem_wr=0 in cycle N+1.
- IO stall:
  - Applies in WRITE when the latched address is IO and io_buffer_full=1.
  - Hold k, mem_wr=0, mem_a unchanged; resume the cycle after io_buffer_full drops.
  - Stall applies before every byte.
- Address arithmetic: addr+k wraps modulo 2^ADDR_WIDTH; no alignment checks.
- done pulses never overlap for the same requester; at most one done per cycle in total.
- A requester must deassert or change its request the cycle after done; the arbiter does not re-grant a request in the cycle its done is visible (done cycle counts as busy for that requester).
- clear=1:
  - In-flight READ (either owner) aborted: next cycle IDLE, no done, mem_wr=0.
  - IDLE: requests ignored that cycle.
  - In-flight WRITE is NOT aborted; it completes and pulses ls_done.
  - clear has no effect on last_grant.
- Unused ls_rdata upper bytes are zero for byte/half loads.
- rst asserted mid-access: immediate return to reset values, partial write abandoned.

Test Plan:
- Fetch only: if_addr=0x100, RAM bytes 0x13,0x05,0x00,0x00 -> if_done in cycle 6, if_data=0x00000513; mem_a sequence 0x100..0x103.
- Concurrent requests, both valid in cycle 0 after reset -> fetch granted first; LSU load half at 0x20 (0xBEEF) granted the cycle fetch completes; ls_rdata=0x0000BEEF.
- Store word 0xDEADBEEF at 0x40 -> mem_wr=1 for 4 cycles, mem_dout EF,BE,AD,DE at 0x40..0x43; ls_done in cycle 5.
- IO store byte 0x41 to 0x30000, io_buffer_full=1 for 3 cycles -> mem_wr held 0, written when full drops; ls_done one cycle later.
- clear pulsed in cycle 3 of a fetch -> no if_done, mem_wr stays 0, IDLE next cycle; clear during a word store -> store completes, ls_done pulses.
- rst low mid-write -> all outputs 0 immediately; after release, first tie granted to fetch.
